// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx line, falling-edge start detect, mid-bit sampling, 1-clk valid pulse.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err output.
module uart_rx #(
  parameter int BAUD     = 434,
  parameter int SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [8:0] L_STROBE  = 9'(BAUD / 2 - 1);
  localparam logic [8:0] L_BIT_END = 9'(BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SYNC_LEN-1:0] r_sync;
  logic                r_rx_d;
  logic [8:0]          r_cnt_bps;
  logic [2:0]          r_cnt_bit;
  logic [7:0]          r_sh;

  logic w_rx_s;
  logic w_fall;
  logic w_strobe;
  logic w_bit_end;
  logic w_shift;
  logic w_load;
  logic w_ferr;
`ifdef UART_RX_PARITY_EN
  logic w_par_chk;
  logic r_par_bad;
`endif

  assign w_rx_s    = r_sync[SYNC_LEN-1];
  assign w_fall    = r_rx_d & ~w_rx_s;
  assign w_strobe  = (r_cnt_bps == L_STROBE);
  assign w_bit_end = (r_cnt_bps == L_BIT_END);
  assign busy      = (r_state != IDLE);

  // Synchroniser and edge-detect flops reset to the idle line level so release never fakes a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
      r_sync <= {r_sync[SYNC_LEN-2:0], rx};
      r_rx_d <= w_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next  = r_state;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_chk = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) w_next = START;
      end
      START: begin
        // A line back high at mid start bit was a glitch, not a frame.
        if (w_strobe && w_rx_s) w_next = IDLE;
        else if (w_bit_end)     w_next = DATA;
      end
      DATA: begin
        w_shift = w_strobe;
        if (w_bit_end && (r_cnt_bit == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        w_par_chk = w_strobe;
        if (w_bit_end) w_next = STOP;
      end
`endif
      STOP: begin
        // Leaving at the stop midpoint leaves half a bit to catch a back-to-back start edge.
        if (w_strobe) begin
          if (w_rx_s) begin
            w_load = 1'b1;
            w_next = IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = BRK;
          end
        end
      end
      BRK: begin
        if (w_rx_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_bps <= '0;
      r_cnt_bit <= '0;
      r_sh      <= '0;
    end else begin
      if (r_state == IDLE || w_bit_end) r_cnt_bps <= '0;
      else                              r_cnt_bps <= r_cnt_bps + 9'd1;

      if (r_state != DATA)  r_cnt_bit <= '0;
      else if (w_bit_end)   r_cnt_bit <= r_cnt_bit + 3'd1;

      if (w_shift) r_sh <= {w_rx_s, r_sh[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 8'h00;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_load) dout <= r_sh;
      dout_vld  <= w_load;
      frame_err <= w_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero; the byte is delivered regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (w_par_chk) r_par_bad <= ^{r_sh, w_rx_s};
      parity_err <= w_load & r_par_bad;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a queue-based frame model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int BAUD     = 434;
  localparam int SYNC_LEN = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT_NOM = (NBITS - 1) * BAUD + BAUD / 2 + SYNC_LEN + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.BAUD(BAUD), .SYNC_LEN(SYNC_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   n_vld = 0;
  int   n_ferr = 0;
  int   t_start = 0;
  int   t_vld = 0;
  logic brk_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: every sent frame yields exactly one event, in order.
  always @(negedge clk) begin
    if (rst_n && (dout_vld || frame_err)) begin
      check("vld_ferr_excl", 32'(dout_vld & frame_err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({dout_vld, frame_err}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_err", 32'(frame_err), 32'(e.ferr));
        if (dout_vld) begin
          check("dout", 32'(dout), 32'(e.data));
          check("busy_at_vld", 32'(busy), 0);
`ifdef UART_RX_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
        end
      end
      if (dout_vld)  begin n_vld++; t_vld = cyc; end
      if (frame_err) n_ferr++;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int len, input logic stop_hi,
                            input int stop_len, input logic par_flip);
    exp_t e;
    e.data = b;
    e.ferr = ~stop_hi;
`ifdef UART_RX_PARITY_EN
    e.perr = par_flip & stop_hi;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    t_start = cyc;
    drive_bit(1'b0, len);
    for (int i = 0; i < 8; i++) drive_bit(b[i], len);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip, len);
`endif
    drive_bit(stop_hi, stop_len);
    if (!stop_hi) begin
      brk_busy = busy;
      drive_bit(1'b1, len);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BAUD) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, lat, gap, len;
    logic [7:0] b;
    logic pf;
    rst_n = 1'b0;
    rx    = 1'b1;

    // T1: outputs stay quiet while held in reset with a toggling line
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rx = 1'($urandom);
      if (i % 20 == 19) check("t1_reset_outs", 32'({dout, dout_vld, frame_err, busy}), 0);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_after_release", 32'({dout, busy}), 0);

    // T2: single byte, ideal timing, latency about 9.5 bits + sync delay
    v0 = n_vld;
    send_frame(8'hA5, BAUD, 1'b1, BAUD, 1'b0);
    wait_drain("t2_drain");
    check("t2_pulses", 32'(n_vld - v0), 1);
    lat = t_vld - t_start;
    check("t2_latency", 32'(lat >= LAT_NOM - 3 && lat <= LAT_NOM + 3), 1);
    repeat (BAUD) @(negedge clk);
    check("t2_dout_hold", 32'(dout), 32'h A5);

    // T3: back-to-back frames with exactly one stop bit
    v0 = n_vld;
    send_frame(8'h00, BAUD, 1'b1, BAUD, 1'b0);
    send_frame(8'hFF, BAUD, 1'b1, BAUD, 1'b0);
    send_frame(8'h55, BAUD, 1'b1, BAUD, 1'b0);
    wait_drain("t3_drain");
    check("t3_pulses", 32'(n_vld - v0), 3);

    // T4: short low glitch is rejected at the start-bit midpoint
    repeat (BAUD) @(negedge clk);
    v0 = n_vld; f0 = n_ferr;
    drive_bit(1'b0, 100);
    check("t4_busy_rise", 32'(busy), 1);
    drive_bit(1'b1, BAUD);
    check("t4_busy_drop", 32'(busy), 0);
    check("t4_no_events", 32'((n_vld - v0) + (n_ferr - f0)), 0);

    // T5: stop bit held low for three bit times, then a clean frame
    v0 = n_vld; f0 = n_ferr;
    send_frame(8'h3C, BAUD, 1'b0, 3 * BAUD, 1'b0);
    check("t5_busy_in_break", 32'(brk_busy), 1);
    check("t5_busy_released", 32'(busy), 0);
    check("t5_ferr_once", 32'(n_ferr - f0), 1);
    check("t5_no_vld", 32'(n_vld - v0), 0);
    check("t5_dout_unchanged", 32'(dout), 32'h55);
    send_frame(8'h81, BAUD, 1'b1, BAUD, 1'b0);
    wait_drain("t5_drain");
    check("t5_next_byte", 32'(dout), 32'h81);

    // T6: +/-3% baud error, then reset mid-DATA, then a normal frame
    v0 = n_vld;
    send_frame(8'hC3, (BAUD * 103) / 100, 1'b1, (BAUD * 103) / 100, 1'b0);
    send_frame(8'hC3, (BAUD * 97) / 100, 1'b1, (BAUD * 97) / 100, 1'b0);
    wait_drain("t6_tol_drain");
    check("t6_tol_pulses", 32'(n_vld - v0), 2);

    repeat (BAUD) @(negedge clk);
    v0 = n_vld; f0 = n_ferr;
    drive_bit(1'b0, BAUD);
    drive_bit(1'b1, BAUD);
    drive_bit(1'b0, BAUD);
    drive_bit(1'b1, BAUD / 2);
    check("t6_busy_pre_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outs", 32'({dout, dout_vld, frame_err, busy}), 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * BAUD) @(negedge clk);
    check("t6_no_pulse", 32'((n_vld - v0) + (n_ferr - f0)), 0);
    send_frame(8'hC3, BAUD, 1'b1, BAUD, 1'b0);
    wait_drain("t6_next_drain");
    check("t6_next_pulse", 32'(n_vld - v0), 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, BAUD, 1'b1, BAUD, 1'b1);
    wait_drain("t6_parity_drain");
`endif

    // Random frames: random data, small baud error, random idle gaps
    v0 = n_vld;
    for (int k = 0; k < 5; k++) begin
      b   = 8'($urandom);
      len = BAUD - 8 + int'($urandom_range(0, 16));
      gap = int'($urandom_range(0, BAUD));
      pf  = 1'($urandom);
      send_frame(b, len, 1'b1, len, pf);
      if (gap > 0) drive_bit(1'b1, gap);
    end
    wait_drain("rand_drain");
    check("rand_pulses", 32'(n_vld - v0), 5);

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
